// File: rtl/matrix_scan_driver_if.sv
// Control and matrix-line bundle for matrix_scan_driver.
// The host drives the master side; the scan driver is the slave.
interface matrix_scan_driver_if #(
    parameter int ROWS = 8,
    parameter int COLS = 4,
    parameter int CW   = 32
);
    // Handshake: start is a level request that is only sampled while busy is low.
    // busy rises on the cycle after start is accepted and stays high until the frame ends.
    // update_done is a single-cycle pulse in the last busy cycle.
    logic                   start;
    logic [ROWS*COLS-1:0]   cells_state;
    logic                   cell_invert;
    logic [CW-1:0]          pulse_cycles;
    logic [CW-1:0]          dead_cycles;
    logic                   busy;
    logic                   update_done;
    logic [ROWS-1:0]        rows;
    logic [COLS-1:0]        cols;
    logic [ROWS-1:0]        rows_enable;
    logic [COLS-1:0]        cols_enable;
    logic [2*ROWS-1:0]      rows_hbridge;
    logic [2*COLS-1:0]      cols_hbridge;
    logic [2:0]             fsm_state;

    modport master (
        output start, cells_state, cell_invert, pulse_cycles, dead_cycles,
        input  busy, update_done, rows, cols, rows_enable, cols_enable,
               rows_hbridge, cols_hbridge, fsm_state
    );

    modport slave (
        input  start, cells_state, cell_invert, pulse_cycles, dead_cycles,
        output busy, update_done, rows, cols, rows_enable, cols_enable,
               rows_hbridge, cols_hbridge, fsm_state
    );
endinterface

// File: rtl/matrix_scan_driver.sv
// Row-major scan of a ROWS x COLS cell matrix, driving each cell through row/column H-bridges.
// Optional: define SKIP_UNCHANGED_EN to skip cells whose latched value equals the last applied value.
module matrix_scan_driver #(
    parameter int ROWS = 8,
    parameter int COLS = 4,
    parameter int CW   = 32
) (
    input logic                  clock,
    input logic                  reset,
    matrix_scan_driver_if.slave  bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        DRIVE   = 3'd2,
        DEAD    = 3'd3,
        ADVANCE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   dead_q;
    logic [N-1:0]    cells_q;
    logic            cur_bit;
    logic            skip_cell;
    logic            cnt_last;
    logic            last_cell;
    logic [31:0]     row_num;
    logic [31:0]     col_num;

    assign cur_bit   = cells_q[idx];
    assign cnt_last  = (cnt <= CW'(1));
    assign last_cell = (idx == IW'(N - 1));
    assign row_num   = 32'(idx) / 32'(COLS);
    assign col_num   = 32'(idx) % 32'(COLS);

`ifdef SKIP_UNCHANGED_EN
    logic [N-1:0] applied_q;

    assign skip_cell = (cur_bit == applied_q[idx]);

    // The applied value only changes once the full drive pulse has been delivered.
    always_ff @(posedge clock) begin
        if (reset) begin
            applied_q <= '0;
        end else if (state == DRIVE && cnt_last) begin
            applied_q[idx] <= cur_bit;
        end
    end
`else
    assign skip_cell = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = SELECT;
            SELECT:  state_n = skip_cell ? ADVANCE : DRIVE;
            DRIVE:   if (cnt_last) state_n = (dead_q == '0) ? ADVANCE : DEAD;
            DEAD:    if (cnt_last) state_n = ADVANCE;
            ADVANCE: state_n = last_cell ? DONE : SELECT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Timing is captured per cell in SELECT so mid-cell input changes wait for the next cell.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx     <= '0;
            cnt     <= '0;
            dead_q  <= '0;
            cells_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cells_q <= bus.cells_state ^ {N{bus.cell_invert}};
                        idx     <= '0;
                    end
                end
                SELECT: begin
                    cnt    <= (bus.pulse_cycles == '0) ? CW'(1) : bus.pulse_cycles;
                    dead_q <= bus.dead_cycles;
                end
                DRIVE:   cnt <= cnt_last ? dead_q : cnt - CW'(1);
                DEAD:    cnt <= cnt - CW'(1);
                ADVANCE: if (!last_cell) idx <= idx + IW'(1);
                default: ;
            endcase
        end
    end

    assign bus.fsm_state = state;

    always_comb begin
        bus.busy         = (state != IDLE);
        bus.update_done  = (state == DONE);
        bus.rows         = '0;
        bus.cols         = '0;
        bus.rows_enable  = '0;
        bus.cols_enable  = '0;
        bus.rows_hbridge = '0;
        bus.cols_hbridge = '0;
        if (state == SELECT || state == DRIVE || state == DEAD) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_num == 32'(r)) begin
                    bus.rows[r] = 1'b1;
                    if (state == DRIVE) begin
                        bus.rows_enable[r]       = 1'b1;
                        bus.rows_hbridge[2*r +: 2] = cur_bit ? 2'b10 : 2'b01;
                    end
                end
            end
            // Column pair is the complement of the row pair so current flows through the cell.
            for (int c = 0; c < COLS; c++) begin
                if (col_num == 32'(c)) begin
                    bus.cols[c] = 1'b1;
                    if (state == DRIVE) begin
                        bus.cols_enable[c]       = 1'b1;
                        bus.cols_hbridge[2*c +: 2] = cur_bit ? 2'b01 : 2'b10;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver on a 2x2 matrix.
// Also covers the SKIP_UNCHANGED_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_matrix_scan_driver;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int CW   = 32;
    localparam int N    = ROWS * COLS;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   exp_done;
    logic [N-1:0] applied_m;
    logic [1:0]   exp_q[$];

    matrix_scan_driver_if #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) bus();

    matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Expected drive sequence (one entry per DRIVE cycle) and done cycle for a frame.
    task automatic build_expected(input logic [N-1:0] latched, input logic [CW-1:0] pulse,
                                  input logic [CW-1:0] dead);
        int pe;
        bit skip;
        pe = (pulse == 0) ? 1 : int'(pulse);
        exp_q.delete();
        exp_done = 1;
        for (int c = 0; c < N; c++) begin
            skip = 1'b0;
`ifdef SKIP_UNCHANGED_EN
            skip = (latched[c] == applied_m[c]);
`endif
            if (skip) begin
                exp_done += 2;
            end else begin
                for (int k = 0; k < pe; k++) exp_q.push_back(2'(c));
                exp_done += 2 + pe + int'(dead);
                applied_m[c] = latched[c];
            end
        end
    endtask

    task automatic wait_done(input int bound, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clock); #1;
            if (bus.update_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: update_done not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic run_frame(input logic [N-1:0] cells, input logic inv, input logic [CW-1:0] pulse,
                             input logic [CW-1:0] dead, input bit hold, input string name);
        logic [N-1:0] latched;
        logic [15:0]  exp_v;
        logic [15:0]  got_v;
        logic [1:0]   c;
        logic         v;
        int           cyc;
        int           row;
        int           col;
        bit           seen;
        latched = cells ^ {N{inv}};
        build_expected(latched, pulse, dead);
        bus.cells_state  = cells;
        bus.cell_invert  = inv;
        bus.pulse_cycles = pulse;
        bus.dead_cycles  = dead;
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock); #1;
        cyc = 1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got %b want 1", name, bus.busy);
        end
        if (!hold) bus.start = 1'b0;
        seen = 1'b0;
        while (!seen && cyc <= exp_done + 5) begin
            if (cyc == 5) bus.cells_state = ~cells;
            got_v = {bus.rows_enable, bus.cols_enable, bus.rows_hbridge, bus.cols_hbridge,
                     bus.rows, bus.cols};
            if (bus.rows_enable != 0 || bus.cols_enable != 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s drive: unexpected drive at cycle %0d got %h", name, cyc, got_v);
                end else begin
                    c   = exp_q.pop_front();
                    v   = latched[c];
                    row = int'(c) / COLS;
                    col = int'(c) % COLS;
                    exp_v[15:14] = 2'b01 << row;
                    exp_v[13:12] = 2'b01 << col;
                    exp_v[11:8]  = (v ? 4'b0010 : 4'b0001) << (2 * row);
                    exp_v[7:4]   = (v ? 4'b0001 : 4'b0010) << (2 * col);
                    exp_v[3:2]   = 2'b01 << row;
                    exp_v[1:0]   = 2'b01 << col;
                    if (got_v !== exp_v) begin
                        errors++;
                        $display("FAIL %s drive cycle %0d cell %0d: got %h want %h", name, cyc, c, got_v, exp_v);
                    end
                end
            end else if (bus.rows_hbridge != 0 || bus.cols_hbridge != 0) begin
                checks++;
                errors++;
                $display("FAIL %s hbridge without enable at cycle %0d: got %h want 0", name, cyc, got_v);
            end
            if (bus.update_done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (cyc != exp_done) begin
                    errors++;
                    $display("FAIL %s done cycle: got %0d want %0d", name, cyc, exp_done);
                end
            end else begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no update_done by cycle %0d want %0d", name, cyc, exp_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing drives: got %0d left want 0", name, exp_q.size());
        end
        @(posedge clock); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.update_done !== 1'b0) begin
            errors++;
            $display("FAIL %s after done: busy %b done %b want 0 0", name, bus.busy, bus.update_done);
        end
        if (hold) begin
            @(posedge clock); #1;
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s restart: busy %b want 1", name, bus.busy);
            end
            bus.start = 1'b0;
            wait_done(100, name);
            applied_m = ~latched;
            @(posedge clock); #1;
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [19:0] got_v;
        got_v = {bus.fsm_state, bus.busy, bus.update_done, bus.rows, bus.cols, bus.rows_enable,
                 bus.cols_enable, bus.rows_hbridge, bus.cols_hbridge};
        checks++;
        if (got_v !== 20'h0) begin
            errors++;
            $display("FAIL %s outputs: got %h want 0", name, got_v);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.cells_state = '1;
        bus.cell_invert = 1'b0;
        bus.pulse_cycles = 3;
        bus.dead_cycles = 2;
        applied_m = '0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        bus.start = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        check_all_zero("idle");
    endtask

    task automatic test_full_frame;
        run_frame(4'b0101, 1'b0, 3, 2, 1'b0, "full_frame");
    endtask

    task automatic test_polarity;
        run_frame(4'b0001, 1'b1, 3, 2, 1'b0, "polarity_inv");
        run_frame(4'b1110, 1'b0, 3, 2, 1'b0, "polarity_plain");
    endtask

    task automatic test_zero_timing;
        run_frame(4'b1010, 1'b0, 0, 0, 1'b0, "zero_timing");
    endtask

    task automatic test_reset_mid_frame;
        bit done_seen;
        bus.cells_state = 4'b0110;
        bus.cell_invert = 1'b0;
        bus.pulse_cycles = 3;
        bus.dead_cycles = 2;
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        applied_m = '0;
        check_all_zero("reset_mid_frame");
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.update_done !== 1'b0 || bus.busy !== 1'b0) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL reset_abort: activity after reset got 1 want 0");
        end
        run_frame(4'b0110, 1'b0, 3, 2, 1'b0, "after_reset");
    endtask

    task automatic test_hold_start;
        run_frame(4'b0110, 1'b0, 2, 1, 1'b1, "hold_start");
    endtask

`ifdef SKIP_UNCHANGED_EN
    task automatic test_skip;
        run_frame(4'b0011, 1'b0, 3, 2, 1'b0, "skip_prime");
        run_frame(4'b0011, 1'b0, 3, 2, 1'b0, "skip_same");
        run_frame(4'b1011, 1'b0, 3, 2, 1'b0, "skip_one_bit");
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.cells_state = '0;
        bus.cell_invert = 1'b0;
        bus.pulse_cycles = '0;
        bus.dead_cycles = '0;
        test_reset;
        test_full_frame;
        test_polarity;
        test_zero_timing;
        test_reset_mid_frame;
        test_hold_start;
`ifdef SKIP_UNCHANGED_EN
        test_skip;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
